// File: rtl/bp_hard_decision_if.sv
// Handshake and result bus between the BP scheduler and the hard-decision /
// early-termination block. The scheduler side uses 'master', the block 'slave'.
interface bp_hard_decision_if #(
  parameter int SIZE = 20,
  parameter int N    = 64
);
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] in_llr;
  logic            busy;
  logic            out_valid;
  logic [N-1:0]    out_bits;
  logic [7:0]      out_iter;
  logic            out_converged;
  logic            stop;

  modport master (
    output start, in_valid, in_llr,
    input  in_ready, busy, out_valid, out_bits, out_iter, out_converged, stop
  );

  modport slave (
    input  start, in_valid, in_llr,
    output in_ready, busy, out_valid, out_bits, out_iter, out_converged, stop
  );
endinterface

// File: rtl/bp_hard_decision.sv
// Hard-decision slicer and early-termination detector for the polar BP decoder.
// Collects N sign bits per iteration, compares each word with the previous one
// and stops after STABLE consecutive matches or after MAX_ITER iterations.
module bp_hard_decision #(
  parameter int SIZE     = 20,
  parameter int N        = 64,
  parameter int STABLE   = 2,
  parameter int MAX_ITER = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  bp_hard_decision_if.slave bus
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int SC_W  = $clog2(STABLE + 1);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
  localparam logic [SC_W-1:0]  STABLE_C   = SC_W'(STABLE);
  localparam logic [7:0]       MAX_ITER_C = 8'(MAX_ITER);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       iter_q, iter_d;
  logic [SC_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic             first_q, first_d;
  logic [N-1:0]     cur_q, cur_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [N-1:0]     out_bits_q, out_bits_d;
  logic [7:0]       out_iter_q, out_iter_d;
  logic             out_conv_q, out_conv_d;

  logic             accept;
  logic             hard_bit;
  logic [N-1:0]     wr_sel;
  logic [7:0]       iter_n;
  logic [SC_W-1:0]  stable_n;

  // Negative LLR -> 1. A set sign bit always implies a non-zero value, so the
  // OR-reduction only restates that zero slices to 0.
  assign hard_bit = bus.in_llr[SIZE-1] & (|bus.in_llr);
  assign accept   = bus.in_valid & bus.in_ready;

  // One-hot select of the word bit written by the current LLR
  for (genvar gi = 0; gi < N; gi++) begin : g_wr_sel
    assign wr_sel[gi] = (idx_q == IDX_W'(gi));
  end

  // Next-state and datapath update; start overrides every state
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    iter_d       = iter_q;
    stable_cnt_d = stable_cnt_q;
    first_d      = first_q;
    cur_d        = cur_q;
    prev_d       = prev_q;
    out_bits_d   = out_bits_q;
    out_iter_d   = out_iter_q;
    out_conv_d   = out_conv_q;
    iter_n       = iter_q + 8'd1;
    stable_n     = stable_cnt_q;

    if (bus.start) begin
      // New frame: anything in flight, including an LLR offered now, is dropped
      state_d      = S_COLLECT;
      idx_d        = '0;
      iter_d       = '0;
      stable_cnt_d = '0;
      first_d      = 1'b1;
      cur_d        = '0;
      prev_d       = '0;
      out_bits_d   = '0;
      out_iter_d   = '0;
      out_conv_d   = 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (accept) begin
            cur_d = (cur_q & ~wr_sel) | (wr_sel & {N{hard_bit}});
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              state_d = S_CHECK;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end

        S_CHECK: begin
          if (first_q) begin
            stable_n = '0;
            first_d  = 1'b0;
          end else if (cur_q == prev_q) begin
            stable_n = (stable_cnt_q == STABLE_C) ? STABLE_C : stable_cnt_q + SC_W'(1);
          end else begin
            stable_n = '0;
          end
          stable_cnt_d = stable_n;
          prev_d       = cur_q;
          iter_d       = iter_n;

          // Convergence takes priority when the cap is reached in the same check
          if (stable_n >= STABLE_C) begin
            state_d    = S_DONE;
            out_bits_d = cur_q;
            out_iter_d = iter_n;
            out_conv_d = 1'b1;
          end else if (iter_n == MAX_ITER_C) begin
            state_d    = S_DONE;
            out_bits_d = cur_q;
            out_iter_d = iter_n;
            out_conv_d = 1'b0;
          end else begin
            state_d = S_COLLECT;
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      iter_q       <= '0;
      stable_cnt_q <= '0;
      first_q      <= 1'b0;
      cur_q        <= '0;
      prev_q       <= '0;
      out_bits_q   <= '0;
      out_iter_q   <= '0;
      out_conv_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      iter_q       <= iter_d;
      stable_cnt_q <= stable_cnt_d;
      first_q      <= first_d;
      cur_q        <= cur_d;
      prev_q       <= prev_d;
      out_bits_q   <= out_bits_d;
      out_iter_q   <= out_iter_d;
      out_conv_q   <= out_conv_d;
    end
  end

  assign bus.in_ready      = (state_q == S_COLLECT);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.out_valid     = (state_q == S_DONE);
  assign bus.stop          = (state_q == S_DONE);
  assign bus.out_bits      = out_bits_q;
  assign bus.out_iter      = out_iter_q;
  assign bus.out_converged = out_conv_q;

endmodule
